// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
//   arb_state_e : arbitration mode (CPU priority, EXT priority, EXT locked)
//   rd_owner_e  : which requester the read data returning next cycle belongs to
//   cnt_width   : counter width for a counter that must hold 0 .. max_val-1
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CPU_PRI  = 2'd0,
    EXT_PRI  = 2'd1,
    EXT_LOCK = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } rd_owner_e;

  // $clog2 of the maximum, kept at least 1 bit so a maximum of 1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk  : clock, rising edge
//   srst : synchronous reset, active-high (count -> 0)
//   clr  : clear to 0 (wins over inc)
//   inc  : increment by one, holding at MAX-1
//   cnt  : current count
module arb_sat_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX = 8,
  localparam int unsigned W  = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] TopVal = W'(MAX - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != TopVal)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory SRAM port between the pipeline MEM stage (CPU) and the
// external load/debug port (EXT). One access is issued per cycle; read data returns one cycle
// later and is flagged to whichever requester issued the read.
//   clk, srst                        : clock / synchronous active-high reset
//   cpu_req/wen/addr/wdata           : CPU request (level, held until granted)
//   cpu_gnt, cpu_stall               : CPU access issued / pipeline freeze
//   cpu_rvalid, cpu_rdata            : CPU read return
//   ext_req/wen/addr/wdata, ext_lock : EXT request; ext_lock keeps exclusive ownership
//   ext_gnt, ext_rvalid, ext_rdata   : EXT grant / read return
//   lock_err                         : sticky, set when a lock is forcibly released
//   mem_addr/wdata/wen/ren, mem_rdata: SRAM side
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              lock_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = cnt_width(MAX_WAIT);
  localparam int unsigned LOCK_W = cnt_width(LOCK_MAX);

  arb_state_e  state_q;
  rd_owner_e   rd_owner_q;
  logic        lock_err_q;

  logic [WAIT_W-1:0] wait_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              wait_at_max;
  logic              lock_at_max;
  logic              ext_denied;
  logic              wait_trip;
  logic              lock_take;
  logic              wait_clr;
  logic              wait_inc;
  logic              lock_clr;
  logic              lock_inc;

  assign wait_at_max = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
  assign lock_at_max = (lock_cnt == LOCK_W'(LOCK_MAX - 1));

  // Grant decode. Nothing is granted while srst is high so the memory sees no access
  // and every output reads as idle during reset.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!srst) begin
      unique case (state_q)
        CPU_PRI: begin
          cpu_gnt = cpu_req;
          ext_gnt = ext_req & ~cpu_req;
        end
        EXT_PRI: begin
          ext_gnt = ext_req;
          cpu_gnt = cpu_req & ~ext_req;
        end
        EXT_LOCK: begin
          ext_gnt = ext_req;
        end
        default: begin
          cpu_gnt = 1'b0;
          ext_gnt = 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt & ~srst;

  // Memory-side mux; all zero when nobody is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
    end
  end

  // Counter controls. EXT can only be denied in CPU_PRI, so wait_cnt only moves there.
  always_comb begin
    ext_denied = ext_req & ~ext_gnt;
    wait_trip  = (state_q == CPU_PRI) & ext_denied & wait_at_max & ~srst;
    lock_take  = ext_gnt & ext_lock;
    wait_clr   = ext_gnt | wait_trip;
    wait_inc   = ext_denied;
    // Held at zero outside the lock so it always starts from 0 on entry.
    lock_clr   = (state_q != EXT_LOCK);
    lock_inc   = (state_q == EXT_LOCK);
  end

  arb_sat_counter #(
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk  (clk),
    .srst (srst),
    .clr  (wait_clr),
    .inc  (wait_inc),
    .cnt  (wait_cnt)
  );

  arb_sat_counter #(
    .MAX (LOCK_MAX)
  ) u_lock_cnt (
    .clk  (clk),
    .srst (srst),
    .clr  (lock_clr),
    .inc  (lock_inc),
    .cnt  (lock_cnt)
  );

  // Arbitration FSM, read-ownership tracking and the sticky lock error.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= CPU_PRI;
      rd_owner_q <= OWN_NONE;
      lock_err_q <= 1'b0;
    end else begin
      if (cpu_gnt && !cpu_wen) begin
        rd_owner_q <= OWN_CPU;
      end else if (ext_gnt && !ext_wen) begin
        rd_owner_q <= OWN_EXT;
      end else begin
        rd_owner_q <= OWN_NONE;
      end

      unique case (state_q)
        CPU_PRI: begin
          if (lock_take) begin
            state_q <= EXT_LOCK;
          end else if (wait_trip) begin
            state_q <= EXT_PRI;
          end
        end
        EXT_PRI: begin
          // Priority lasts exactly one cycle whether or not EXT used it.
          state_q <= lock_take ? EXT_LOCK : CPU_PRI;
        end
        EXT_LOCK: begin
          // Forced release beats ext_lock; the access this cycle is still granted.
          if (lock_at_max) begin
            state_q    <= CPU_PRI;
            lock_err_q <= 1'b1;
          end else if (ext_gnt && !ext_lock) begin
            state_q <= CPU_PRI;
          end
        end
        default: begin
          state_q <= CPU_PRI;
        end
      endcase
    end
  end

  assign cpu_rvalid = (rd_owner_q == OWN_CPU) & ~srst;
  assign ext_rvalid = (rd_owner_q == OWN_EXT) & ~srst;
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;
  assign lock_err   = lock_err_q & ~srst;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned MW  = 8;
  localparam int unsigned LM  = 16;
  localparam logic [63:0] KEY = 64'h5a5a_c3c3_0f0f_9696;

  logic          clk = 1'b0;
  logic          srst;
  logic          cpu_req, cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req, ext_wen, ext_lock;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          lock_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  // SRAM stand-in: read data is a keyed function of the address read one cycle earlier.
  always @(posedge clk) mem_rdata <= mem_ren ? (mem_addr ^ KEY) : 64'h0;

  dmem_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW),
    .LOCK_MAX (LM)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_wen    (ext_wen),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_lock   (ext_lock),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .lock_err   (lock_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata)
  );

  // Reference model: lock flag with an age in cycles, a denial tally, a one-shot EXT boost,
  // and the owner of the read in flight.
  bit          m_locked, m_boost, m_lock_err;
  int          m_lock_age, m_denied, m_owner;
  logic [63:0] m_rdata;
  logic        e_cg, e_eg;

  int n_cmp = 0;
  int n_bad = 0;
  logic obs_cg, obs_eg, obs_crv, obs_lerr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    e_cg = 1'b0;
    e_eg = 1'b0;
    if (!srst) begin
      if (m_locked) begin
        e_eg = ext_req;
      end else if (m_boost) begin
        e_eg = ext_req;
        e_cg = cpu_req && !ext_req;
      end else begin
        e_cg = cpu_req;
        e_eg = ext_req && !cpu_req;
      end
    end
  endtask

  task automatic model_seq();
    if (srst) begin
      m_locked = 0; m_boost = 0; m_lock_err = 0;
      m_lock_age = 0; m_denied = 0; m_owner = 0;
    end else begin
      if (e_cg && !cpu_wen) begin
        m_owner = 1; m_rdata = cpu_addr ^ KEY;
      end else if (e_eg && !ext_wen) begin
        m_owner = 2; m_rdata = ext_addr ^ KEY;
      end else begin
        m_owner = 0;
      end
      if (m_locked) begin
        m_lock_age++;
        if (m_lock_age >= int'(LM)) begin
          m_locked = 0; m_lock_err = 1;
        end else if (e_eg && !ext_lock) begin
          m_locked = 0;
        end
      end else if (e_eg && ext_lock) begin
        m_locked = 1; m_lock_age = 0; m_boost = 0; m_denied = 0;
      end else if (m_boost) begin
        m_boost = 0; m_denied = 0;
      end else if (e_eg) begin
        m_denied = 0;
      end else if (ext_req) begin
        m_denied++;
        if (m_denied >= int'(MW)) begin
          m_boost = 1; m_denied = 0;
        end
      end
    end
  endtask

  // One clock cycle with the currently applied inputs: check at the falling edge, advance
  // the model at the rising edge.
  task automatic tick();
    logic [63:0] ea, ed;
    @(negedge clk);
    model_comb();
    ea = e_cg ? cpu_addr : (e_eg ? ext_addr : 64'h0);
    ed = e_cg ? cpu_wdata : (e_eg ? ext_wdata : 64'h0);
    obs_cg = cpu_gnt; obs_eg = ext_gnt; obs_crv = cpu_rvalid; obs_lerr = lock_err;
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("ext_gnt", ext_gnt, e_eg);
    chk("cpu_stall", cpu_stall, cpu_req && !e_cg && !srst);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("mem_wen", mem_wen, (e_cg && cpu_wen) || (e_eg && ext_wen));
    chk("mem_ren", mem_ren, (e_cg && !cpu_wen) || (e_eg && !ext_wen));
    chk("cpu_rvalid", cpu_rvalid, !srst && m_owner == 1);
    chk("ext_rvalid", ext_rvalid, !srst && m_owner == 2);
    chk("lock_err", lock_err, !srst && m_lock_err);
    if (!srst && m_owner == 1) chk("cpu_rdata", cpu_rdata, m_rdata);
    if (!srst && m_owner == 2) chk("ext_rdata", ext_rdata, m_rdata);
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic cpu(input logic req, input logic wen, input logic [63:0] addr);
    cpu_req = req; cpu_wen = wen; cpu_addr = addr; cpu_wdata = {$urandom, $urandom};
  endtask

  task automatic ext(input logic req, input logic wen, input logic lock,
                     input logic [63:0] addr);
    ext_req = req; ext_wen = wen; ext_lock = lock; ext_addr = addr;
    ext_wdata = {$urandom, $urandom};
  endtask

  initial begin
    int first;
    srst = 1'b1;
    cpu(0, 0, 0);
    ext(0, 0, 0, 0);
    @(posedge clk);
    #1;
    tick();
    srst = 1'b0;
    tick();

    // 1: lone CPU read, data back next cycle.
    cpu(1, 0, 64'h10);
    tick();
    chk("t1_gnt", obs_cg, 1'b1);
    cpu(0, 0, 0);
    tick();
    chk("t1_rvalid", obs_crv, 1'b1);

    // 2: both requesting reads; EXT gets the ninth slot.
    first = -1;
    cpu(1, 0, 64'h100);
    ext(1, 0, 0, 64'h200);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_eg && first < 0) first = i;
    end
    chk("t2_ext_slot", 64'(first), 64'd8);
    cpu(0, 0, 0);
    ext(0, 0, 0, 0);
    tick();

    // 3: alternating reads.
    cpu(1, 0, 64'h20);
    tick();
    cpu(0, 0, 0);
    ext(1, 0, 0, 64'h28);
    tick();
    cpu(1, 0, 64'h30);
    ext(0, 0, 0, 0);
    tick();
    cpu(0, 0, 0);
    tick();
    tick();

    // 4: locked EXT write then three locked reads with the CPU waiting, then unlock.
    ext(1, 1, 1, 64'h40);
    tick();
    cpu(1, 0, 64'h50);
    for (int i = 0; i < 3; i++) begin
      ext(1, 0, 1, 64'h48 + 64'(i * 8));
      tick();
      chk("t4_cpu_blocked", obs_cg, 1'b0);
    end
    ext(1, 0, 0, 64'h60);
    tick();
    ext(0, 0, 0, 0);
    tick();
    chk("t4_cpu_back", obs_cg, 1'b1);
    cpu(0, 0, 0);
    tick();

    // 5: lock held past its limit, including an idle EXT cycle inside the lock.
    ext(1, 0, 1, 64'h80);
    tick();
    cpu(1, 0, 64'h90);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) ext(0, 0, 1, 64'h88);
      else ext(1, 0, 1, 64'h88 + 64'(i));
      tick();
      if (obs_cg && first < 0) first = i;
    end
    chk("t5_cpu_slot", 64'(first), 64'd16);
    chk("t5_lock_err", obs_lerr, 1'b1);
    cpu(0, 0, 0);
    ext(0, 0, 0, 0);
    tick();

    // 6: reset right after a CPU read grant, and reset while locked.
    cpu(1, 0, 64'hA0);
    ext(1, 0, 1, 64'hA8);
    tick();
    srst = 1'b1;
    tick();
    chk("t6_rvalid", obs_crv, 1'b0);
    chk("t6_lock_err", obs_lerr, 1'b0);
    srst = 1'b0;
    cpu(0, 0, 0);
    ext(1, 1, 1, 64'hB0);
    tick();
    cpu(1, 0, 64'hB8);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    ext(1, 0, 1, 64'hC0);
    tick();
    chk("t6_cpu_after", obs_cg, 1'b1);

    // Randomized traffic against the model; lock-heavy and lock-light segments alternate.
    for (int i = 0; i < 800; i++) begin
      int lp;
      lp = ((i / 60) % 2 == 1) ? 95 : 20;
      srst = ($urandom_range(0, 199) == 0);
      cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, {$urandom, $urandom});
      ext($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < lp, {$urandom, $urandom});
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
